l2_i_refill_responder: RTL and testbench

- L2-side responder for L1 instruction-cache refill requests.
- Accepts a line request ({tag, index}) from the L1 I-cache and fetches the 512-bit line from the memory side as a burst of narrow beats.
- Assembles the beats into a full line and returns it to L1 with a one-cycle ready pulse.
- Sits between the L1 I-cache refill port and the memory/L2 backing interface.

---
 rtl/l2_i_pkg.sv | 25 ++
 rtl/l2_i_refill_responder_line_assembler.sv | 58 +++++
 rtl/l2_i_refill_responder.sv | 201 ++++++++++++++++++++
 tb/tb_l2_i_refill_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_i_pkg.sv
// Shared definitions for the L2 instruction-refill responder: default widths,
// derived beat count / beat-counter width, and the FSM state encoding.
package l2_i_pkg;

    localparam int DEF_TAG_W   = 21;
    localparam int DEF_INDEX_W = 5;
    localparam int DEF_LINE_W  = 512;
    localparam int DEF_BEAT_W  = 128;

    // Width of a counter that indexes every beat of a line (at least one bit).
    function automatic int beat_cnt_w(input int line_w, input int beat_w);
        return ((line_w / beat_w) > 1) ? $clog2(line_w / beat_w) : 1;
    endfunction

    localparam int NUM_BEATS = DEF_LINE_W / DEF_BEAT_W;
    localparam int CNT_W     = beat_cnt_w(DEF_LINE_W, DEF_BEAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/l2_i_refill_responder_line_assembler.sv
// Collects in-order memory beats into a full cache line.
// The line output is the post-beat image (includes the beat arriving this
// cycle), so the parent can capture a complete line on the last beat.
module l2_i_line_assembler
    import l2_i_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int NUM_B  = NUM_BEATS,
    parameter int CNT_B  = CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rvalid,
    input  logic [BEAT_W-1:0] rdata,
    output logic [LINE_W-1:0] line,
    output logic              last
);

    localparam logic [CNT_B-1:0] LAST_IDX = CNT_B'(NUM_B - 1);
    localparam logic [CNT_B-1:0] CNT_ONE  = CNT_B'(1);

    logic [CNT_B-1:0]  cnt_q;
    logic [CNT_B-1:0]  cnt_d;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    // Place the incoming beat at its slot and advance the beat index.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        last   = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (rvalid) begin
            line_d[int'(cnt_q) * BEAT_W +: BEAT_W] = rdata;
            last  = (cnt_q == LAST_IDX);
            cnt_d = (cnt_q == LAST_IDX) ? '0 : (cnt_q + CNT_ONE);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Beat counter and partial-line storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line = line_d;

endmodule

// File: rtl/l2_i_refill_responder.sv
// L2-side responder for L1 I-cache refills: latches the line address, issues
// one memory request, assembles the beat burst and returns the line with a
// single-cycle ready pulse.
// Optional macro L2_I_LINE_BUF_EN adds a one-entry buffer of the last line.
module l2_i_refill_responder
    import l2_i_pkg::*;
#(
    parameter int TAG_W   = DEF_TAG_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int BEAT_W  = DEF_BEAT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read_L1_L2,
    input  logic [TAG_W-1:0]         tag_L1_L2,
    input  logic [INDEX_W-1:0]       index_L1_L2,
    output logic [LINE_W-1:0]        read_data_L2_L1,
    output logic                     ready_L2_L1,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [TAG_W+INDEX_W-1:0] mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [BEAT_W-1:0]        mem_rdata
);

    localparam int ADDR_W = TAG_W + INDEX_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_req_q, mem_req_d;
    logic                ready_q, ready_d;
    logic                skip_q, skip_d;   // one-cycle blind window after RESP
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    logic                asm_clear_s;
    logic                asm_rvalid_s;
    logic                asm_last_s;
    logic [LINE_W-1:0]   asm_line_s;
    logic [ADDR_W-1:0]   req_addr_s;
    logic                hit_s;

`ifdef L2_I_LINE_BUF_EN
    logic                buf_valid_q, buf_valid_d;
    logic                flushed_q, flushed_d;   // flush seen while line in flight
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [LINE_W-1:0]   buf_line_q, buf_line_d;

    assign hit_s = buf_valid_q && !flush && (buf_addr_q == req_addr_s);
`else
    logic                unused_flush_s;

    assign unused_flush_s = flush;
    assign hit_s          = 1'b0;
`endif

    assign req_addr_s   = {tag_L1_L2, index_L1_L2};
    // Beats only count while filling; any other state keeps the counter at 0.
    assign asm_clear_s  = (state_q != FILL);
    assign asm_rvalid_s = mem_rvalid && (state_q == FILL);

    l2_i_line_assembler #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .NUM_B  (LINE_W / BEAT_W),
        .CNT_B  (beat_cnt_w(LINE_W, BEAT_W))
    ) u_asm (
        .clk    (clk),
        .rst    (rst),
        .clear  (asm_clear_s),
        .rvalid (asm_rvalid_s),
        .rdata  (mem_rdata),
        .line   (asm_line_s),
        .last   (asm_last_s)
    );

    // Next-state, registered-output and line-buffer update logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mem_req_d = 1'b0;
        ready_d   = 1'b0;
        skip_d    = 1'b0;
        rdata_d   = rdata_q;
`ifdef L2_I_LINE_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_line_d  = buf_line_q;
        flushed_d   = flushed_q;
`endif
        case (state_q)
            IDLE: begin
                if (read_L1_L2 && !skip_q) begin
                    addr_d = req_addr_s;
`ifdef L2_I_LINE_BUF_EN
                    flushed_d = 1'b0;
`endif
                    if (hit_s) begin
`ifdef L2_I_LINE_BUF_EN
                        rdata_d = buf_line_q;
`endif
                        ready_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = FILL;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            FILL: begin
                if (asm_last_s) begin
                    rdata_d = asm_line_s;
                    ready_d = 1'b1;
                    state_d = RESP;
`ifdef L2_I_LINE_BUF_EN
                    if (!flushed_q && !flush) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = addr_q;
                        buf_line_d  = asm_line_s;
                    end else begin
                        buf_valid_d = 1'b0;
                    end
`endif
                end else begin
                    state_d = FILL;
                end
            end
            RESP: begin
                skip_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef L2_I_LINE_BUF_EN
        if (flush) begin
            buf_valid_d = 1'b0;
            if ((state_q == REQ) || (state_q == FILL)) begin
                flushed_d = 1'b1;
            end else begin
                flushed_d = flushed_d;
            end
        end else begin
            buf_valid_d = buf_valid_d;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mem_req_q <= 1'b0;
            ready_q   <= 1'b0;
            skip_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mem_req_q <= mem_req_d;
            ready_q   <= ready_d;
            skip_q    <= skip_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef L2_I_LINE_BUF_EN
    // One-entry buffer of the last delivered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            flushed_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_line_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            flushed_q   <= flushed_d;
            buf_addr_q  <= buf_addr_d;
            buf_line_q  <= buf_line_d;
        end
    end
`endif

    assign read_data_L2_L1 = rdata_q;
    assign ready_L2_L1     = ready_q;
    assign mem_req         = mem_req_q;
    assign mem_addr        = addr_q;

endmodule

// File: tb/tb_l2_i_refill_responder.sv
// Self-checking bench for l2_i_refill_responder: directed vector table,
// hand-written reset / buffer / back-to-back sequences and a randomized run
// against a transaction-level model (line = beats in order, latency from the
// request/grant/beat cycle counts, last-line buffer when enabled).
`timescale 1ns/1ps
module tb_l2_i_refill_responder;

`ifdef L2_I_LINE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          read;
    logic [20:0]   tag;
    logic [4:0]    idx;
    logic [511:0]  read_data;
    logic          ready;
    logic          flush;
    logic          mem_req;
    logic [25:0]   mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [127:0]  mem_rdata;

    always #5 clk = ~clk;

    l2_i_refill_responder dut (
        .clk             (clk),
        .rst             (rst),
        .read_L1_L2      (read),
        .tag_L1_L2       (tag),
        .index_L1_L2     (idx),
        .read_data_L2_L1 (read_data),
        .ready_L2_L1     (ready),
        .flush           (flush),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of the last-line buffer.
    bit            m_valid = 1'b0;
    logic [25:0]   m_addr  = '0;
    logic [511:0]  m_line  = '0;

    typedef struct {
        logic [20:0]  tag;
        logic [4:0]   idx;
        int           d;        // grant delay in cycles
        logic [15:0]  gv;       // nibble k = idle cycles before beat k
        logic [511:0] line;
        bit           spur;     // spurious rvalid in IDLE/REQ
        int           exp_ready;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One L1 request, issued right after a falling edge (that cycle is cycle 0).
    // extra: cycles the DUT is expected to ignore the request first.
    task automatic run_txn(input string name, input logic [20:0] t, input logic [4:0] ix,
                           input int d, input logic [15:0] gv, input logic [511:0] ln,
                           input int extra, input bit hold, input bit spur,
                           output int ready_cyc);
        int cyc, req_cycles, first_req, last_beat_cyc, beat_i, gap_cnt, gnt_wait, exp_ready, exp_req;
        bit granted, hit;
        logic [511:0] got_line, exp_line;
        logic [25:0]  got_addr, a;
        a        = {t, ix};
        hit      = BUF_EN && m_valid && (m_addr == a);
        exp_line = hit ? m_line : ln;
        if (hit) begin
            exp_ready = 1 + extra;
            exp_req   = 0;
        end else begin
            exp_ready = 1 + extra + d + 1;
            for (int k = 0; k < 4; k++) exp_ready += int'(gv[k*4 +: 4]) + 1;
            exp_req = d + 1;
        end
        read = 1'b1; tag = t; idx = ix;
        mem_gnt = 1'b0; mem_rvalid = spur; mem_rdata = {4{$urandom}};
        cyc = 0; ready_cyc = -1; req_cycles = 0; first_req = -1; last_beat_cyc = -1;
        granted = 1'b0; beat_i = 0; gap_cnt = 0; gnt_wait = d;
        got_line = '0; got_addr = '0;
        while (ready_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = spur ? {4{$urandom}} : '0;
            if (ready) begin
                ready_cyc = cyc;
                got_line  = read_data;
            end else begin
                if (mem_req) begin
                    req_cycles++;
                    if (first_req < 0) first_req = cyc;
                    got_addr = mem_addr;
                end
                if (!granted && mem_req) begin
                    if (gnt_wait == 0) begin
                        mem_gnt = 1'b1; granted = 1'b1; gap_cnt = int'(gv[3:0]);
                    end else begin
                        gnt_wait--;
                        mem_rvalid = spur;
                    end
                end else if (granted && beat_i < 4) begin
                    if (gap_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = ln[beat_i*128 +: 128];
                        last_beat_cyc = cyc;
                        beat_i++;
                        if (beat_i < 4) gap_cnt = int'(gv[beat_i*4 +: 4]);
                    end else begin
                        gap_cnt--;
                    end
                end
            end
        end
        mem_rvalid = 1'b0;
        if (ready_cyc < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: got no ready expected ready by cycle %0d", name, exp_ready);
        end else begin
            chk_i({name, " ready_cycle"}, ready_cyc, exp_ready);
            chk({name, " line"}, got_line, exp_line);
            chk_i({name, " mem_req_cycles"}, req_cycles, exp_req);
            if (!hit) begin
                chk({name, " mem_addr"}, got_addr, a);
                chk_i({name, " first_req"}, first_req, 1 + extra);
                chk_i({name, " ready_after_last_beat"}, ready_cyc, last_beat_cyc + 1);
                m_valid = 1'b1; m_addr = a; m_line = ln;
            end
        end
        if (!hold) begin
            @(negedge clk);
            chk({name, " single_pulse"}, ready, 1'b0);
            read = 1'b0;
            @(negedge clk);
            chk({name, " idle_ready"}, ready, 1'b0);
            chk({name, " idle_mem_req"}, mem_req, 1'b0);
            chk({name, " data_held"}, read_data, exp_line);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        int rc;
        logic [20:0]  lt;
        logic [4:0]   li;
        logic [511:0] rl;
        logic [15:0]  rg;

        vecs[0] = '{21'h1ABCD, 5'h0A, 0, 16'h0000,
                    {{16{8'h33}}, {16{8'h22}}, {16{8'h11}}, {16{8'h00}}}, 1'b0, 6};
        vecs[1] = '{21'h00F0F, 5'h1F, 3, 16'h1110,
                    {128'hD3D3_0000_0000_0000_0000_0000_0000_0003, 128'hC2C2_0000_0000_0000_0000_0000_0000_0002,
                     128'hB1B1_0000_0000_0000_0000_0000_0000_0001, 128'hA0A0_0000_0000_0000_0000_0000_0000_0000}, 1'b0, 12};
        vecs[2] = '{21'h12345, 5'h03, 2, 16'h0000,
                    {128'h4444_4444_0000_0000_0000_0000_DDDD_DDDD, 128'h3333_3333_0000_0000_0000_0000_CCCC_CCCC,
                     128'h2222_2222_0000_0000_0000_0000_BBBB_BBBB, 128'h1111_1111_0000_0000_0000_0000_AAAA_AAAA}, 1'b1, 8};
        vecs[3] = '{21'h1FFFFF, 5'h00, 1, 16'h2000,
                    {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0,
                     128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A}, 1'b0, 9};

        rst = 1'b1; read = 1'b0; tag = '0; idx = '0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset ready", ready, 1'b0);
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset mem_addr", mem_addr, 26'h0);
        chk("reset read_data", read_data, 512'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        for (int v = 0; v < 4; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].tag, vecs[v].idx, vecs[v].d, vecs[v].gv,
                    vecs[v].line, 0, 1'b0, vecs[v].spur, rc);
            chk_i($sformatf("vec%0d table_ready", v), rc, vecs[v].exp_ready);
        end

        // Reset in the middle of a fill, then a fresh request.
        read = 1'b1; tag = 21'h0BEEF; idx = 5'h11;
        @(negedge clk);
        chk("rstfill mem_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = {4{32'hDEAD0000}};
        @(negedge clk);
        mem_rdata = {4{32'hDEAD0001}};
        @(negedge clk);
        rst = 1'b1; read = 1'b0; mem_rdata = {4{32'hDEAD0002}};
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b0;
        m_valid = 1'b0;
        chk("rstfill ready", ready, 1'b0);
        chk("rstfill mem_req", mem_req, 1'b0);
        chk("rstfill mem_addr", mem_addr, 26'h0);
        chk("rstfill read_data", read_data, 512'h0);
        run_txn("after_rst", 21'h0BEEF, 5'h11, 0, 16'h0000, rand_line(), 0, 1'b0, 1'b1, rc);

        // Repeat the same line (buffer hit when enabled), then flush and repeat.
        rl = rand_line();
        run_txn("buf_fill", 21'h13579, 5'h15, 1, 16'h0000, rl, 0, 1'b0, 1'b0, rc);
        run_txn("buf_repeat", 21'h13579, 5'h15, 0, 16'h0000, rand_line(), 0, 1'b0, 1'b0, rc);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_valid = 1'b0;
        run_txn("after_flush", 21'h13579, 5'h15, 0, 16'h0000, rand_line(), 0, 1'b0, 1'b0, rc);

        // Back-to-back: request stays high through the response.
        run_txn("b2b_first", 21'h0AAAA, 5'h01, 0, 16'h0000, rand_line(), 0, 1'b1, 1'b0, rc);
        @(negedge clk);
        chk("b2b single_pulse", ready, 1'b0);
        run_txn("b2b_second", 21'h15555, 5'h1E, 0, 16'h0000, rand_line(), 1, 1'b0, 1'b0, rc);

        // Randomized requests, occasionally repeating the previous address.
        lt = 21'h0; li = 5'h0;
        for (int r = 0; r < 16; r++) begin
            if (r == 0 || $urandom_range(0, 3) != 0) begin
                lt = 21'($urandom);
                li = 5'($urandom);
            end
            rg = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
                  4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
            run_txn($sformatf("rand%0d", r), lt, li, int'($urandom_range(0, 3)), rg, rand_line(),
                    0, 1'b0, 1'($urandom_range(0, 1)), rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
